demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter N, default 8: data width in bits; legal range 1..64.
REQ-002 Parameter CH, default 4: output channel count; legal range 2..16.
REQ-003 Parameter SELW, default $clog2(CH): select width; not overridden by instantiators.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  N  upstream data word.
REQ-007 valid_in  input  1  upstream word present.
REQ-008 ready_out  output  1  block can accept the word on data_in this cycle.
REQ-009 selection_i  input  SELW  destination channel index.
REQ-010 bcast_i  input  1  1 = deliver the word to every channel; selection_i is ignored.
REQ-011 result_o  output  CH*N  channel k data on bits [k*N +: N].
REQ-012 valid_o  output  CH  channel k holds a word.
REQ-013 ready_i  input  CH  downstream channel k consumes its word.
REQ-014 drop_cnt_o  output  8  count of words discarded for an out-of-range select.

Function
REQ-015 Each channel has a single-entry output register and a full flag; valid_o[k] is that channel's full flag.
REQ-016 result_o slice k is the register contents while valid_o[k]=1, and all zeros while valid_o[k]=0.
REQ-017 Channel k drains in any cycle where valid_o[k]=1 and ready_i[k]=1; its full flag clears at that edge unless the channel is reloaded in the same cycle.
REQ-018 A channel is free this cycle when valid_o[k]=0 or it drains this cycle. ready_out may depend combinationally on ready_i.
REQ-019 Unicast (bcast_i=0) with selection_i < CH: ready_out = free(selection_i).
REQ-020 Broadcast (bcast_i=1): ready_out = 1 only when every channel is free; no partial delivery.
REQ-021 Unicast with selection_i >= CH: ready_out = 1; the word is discarded and no channel changes.
REQ-022 A transfer occurs when valid_in=1 and ready_out=1.
  - The word loads into the target register(s) at that edge.
  - The full flag(s) set, and valid_o is visible on the next cycle (1-cycle latency).
REQ-023 Simultaneous drain and load on one channel: the new word replaces the old and valid_o stays 1, giving 1 word per cycle per channel.
REQ-024 Each discarded word (REQ-021) increments drop_cnt_o by 1. The counter saturates at 255 and does not wrap.
REQ-025 When valid_in=0, no register or counter changes except drains; data_in, selection_i and bcast_i are don't-care.
REQ-026 A word waiting with valid_in=1 and ready_out=0 is not consumed. Upstream holds data_in, selection_i and bcast_i stable until the transfer.
REQ-027 Channels are independent: backpressure on channel j never blocks a unicast to channel k ≠ j.

Reset
REQ-028 rst_n=0 immediately, without a clock edge, forces:
  - all valid_o = 0 and result_o = 0;
  - all output registers = 0;
  - drop_cnt_o = 0.
REQ-029 ready_out during reset follows REQ-019..021 from the cleared state; a word offered during reset is not captured.
REQ-030 Reset asserted mid-operation discards all buffered words.
REQ-031 After rst_n deasserts, the first transfer occurs on the first rising edge where REQ-022 holds.

Verification
REQ-032 N=8, CH=4, all ready_i=0: send 0xA5 to channel 2 -> next cycle valid_o=0100, slice 2=0xA5, other slices 0. A second send to channel 2 sees ready_out=0. A send to channel 1 is accepted.
REQ-033 Channel 0 full, ready_i[0]=1, send 0x3C to channel 0 in the same cycle -> ready_out=1, valid_o[0] stays 1, slice 0=0x3C next cycle. Hold this for 8 consecutive cycles -> 8 words delivered.
REQ-034 bcast_i=1, channel 3 full and ready_i[3]=0 -> ready_out=0 and no channel loads. Raise ready_i[3] -> 0x77 appears on all four slices next cycle with valid_o=1111.
REQ-035 CH=3, selection_i=3: send 300 words -> ready_out=1 throughout, no valid_o change, drop_cnt_o=255 (saturated).
REQ-036 Channels 1 and 2 full, drop_cnt_o=5; pulse rst_n low between clock edges -> valid_o=0, result_o=0 and drop_cnt_o=0 before the next edge. After release, a send to channel 1 is accepted.

Source files
------------

// File: rtl/demux_stream.sv
// Stream demultiplexer: routes each upstream word to one channel (or all, on
// broadcast) through per-channel single-entry output registers.
module demux_stream #(
  parameter int unsigned N    = 8,
  parameter int unsigned CH   = 4,
  parameter int unsigned SELW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    data_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [SELW-1:0] selection_i,
  input  logic            bcast_i,
  output logic [CH*N-1:0] result_o,
  output logic [CH-1:0]   valid_o,
  input  logic [CH-1:0]   ready_i,
  output logic [7:0]      drop_cnt_o
);

  localparam int unsigned CW = 8;

  logic [CH-1:0][N-1:0] data_q;
  logic [CH-1:0]        full_q;
  logic [CW-1:0]        drop_q;

  logic [CH-1:0] drain;
  logic [CH-1:0] free;
  logic [CH-1:0] target;
  logic [CH-1:0] load;
  logic          sel_ok;
  logic          xfer;
  logic          drop;

  // Acceptance, per-channel load/drain decode and discard detection.
  always_comb begin
    sel_ok = ({1'b0, selection_i} < (SELW+1)'(CH));
    target = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (selection_i == SELW'(k)) target[k] = 1'b1;
    end
    drain = full_q & ready_i;
    free  = ~full_q | ready_i;
    if (bcast_i)     ready_out = &free;
    else if (sel_ok) ready_out = |(target & free);
    else             ready_out = 1'b1;
    xfer = valid_in & ready_out;
    load = '0;
    if (xfer) load = bcast_i ? '1 : target;
    drop = xfer & ~bcast_i & ~sel_ok;
  end

  // A drained register is cleared so result_o reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= '0;
    end else begin
      for (int unsigned k = 0; k < CH; k++) begin
        if (load[k]) begin
          data_q[k] <= data_in;
          full_q[k] <= 1'b1;
        end else if (drain[k]) begin
          data_q[k] <= '0;
          full_q[k] <= 1'b0;
        end
      end
    end
  end

  // Saturating discard counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + CW'(1);
    end
  end

  assign result_o   = data_q;
  assign valid_o    = full_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: a CH=4 instance with per-channel expected
// queues, and a CH=3 instance exercising out-of-range discard and reset.
module tb_demux_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  sel;
  logic        bcast;
  logic [31:0] result_o;
  logic [3:0]  valid_o;
  logic [3:0]  ready_i;
  logic [7:0]  drop_cnt_o;

  logic [7:0]  b_data;
  logic        b_valid_in;
  logic        b_ready_out;
  logic [1:0]  b_sel;
  logic        b_bcast;
  logic [23:0] b_result;
  logic [2:0]  b_valid_o;
  logic [2:0]  b_ready_i;
  logic [7:0]  b_drop;

  int checks   = 0;
  int failures = 0;
  logic [7:0] q [4][$];

  always #5 clk = ~clk;

  demux_stream #(.N(8), .CH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .selection_i(sel), .bcast_i(bcast),
    .result_o(result_o), .valid_o(valid_o), .ready_i(ready_i),
    .drop_cnt_o(drop_cnt_o)
  );

  demux_stream #(.N(8), .CH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(b_data), .valid_in(b_valid_in),
    .ready_out(b_ready_out), .selection_i(b_sel), .bcast_i(b_bcast),
    .result_o(b_result), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .drop_cnt_o(b_drop)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Per-channel output check against the queue head; pop when the word drains.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("valid_o[%0d]", k), 64'(valid_o[k]), 64'(q[k].size() != 0));
      if (q[k].size() != 0) begin
        chk($sformatf("slice%0d", k), 64'(result_o[k*8 +: 8]), 64'(q[k][0]));
        if (ready_i[k]) void'(q[k].pop_front());
      end else begin
        chk($sformatf("slice%0d_zero", k), 64'(result_o[k*8 +: 8]), 64'h0);
      end
    end
    chk("a_drop", 64'(drop_cnt_o), 64'h0);
  end

  // One-cycle offer to the CH=4 instance; expected ready from scoreboard state.
  task automatic offer(input int ch, input logic bc, input logic [7:0] d, input logic v);
    logic [3:0] fr;
    logic       er;
    sel = 2'(ch); bcast = bc; data_in = d; valid_in = v;
    @(negedge clk); #1;
    for (int k = 0; k < 4; k++) fr[k] = (q[k].size() == 0) || ready_i[k];
    er = bc ? &fr : fr[ch];
    chk("ready_out", 64'(ready_out), 64'(er));
    if (v && er) begin
      if (bc) for (int k = 0; k < 4; k++) q[k].push_back(d);
      else q[ch].push_back(d);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic b_offer(input logic [1:0] s, input logic [7:0] d, input logic er);
    b_sel = s; b_data = d; b_valid_in = 1'b1;
    @(negedge clk); #1;
    chk("b_ready", 64'(b_ready_out), 64'(er));
    @(posedge clk); #1;
    b_valid_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    data_in = 8'h99; valid_in = 1'b1; sel = 2'd2; bcast = 1'b0; ready_i = '0;
    b_data = '0; b_valid_in = 1'b0; b_sel = '0; b_bcast = 1'b0; b_ready_i = '0;
    #2;
    chk("rst_ready", 64'(ready_out), 64'h1);
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_result", 64'(result_o), 64'h0);
    chk("rst_drop", 64'(drop_cnt_o), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; valid_in = 1'b0;

    // Unicast with backpressure on one channel, other channel still accepted.
    offer(2, 1'b0, 8'hA5, 1'b1);
    @(negedge clk); #1 chk("v_0100", 64'(valid_o), 64'h4);
    chk("res_a5", 64'(result_o), 64'h00A50000);
    @(posedge clk); #1;
    offer(2, 1'b0, 8'h5A, 1'b1);
    offer(1, 1'b0, 8'h12, 1'b1);
    ready_i = 4'b0110;
    @(posedge clk); #1 ready_i = '0;

    // Same-cycle drain and reload on channel 0, 8 back-to-back words.
    offer(0, 1'b0, 8'h11, 1'b1);
    ready_i = 4'b0001;
    for (int i = 0; i < 8; i++) offer(0, 1'b0, 8'(8'h3C + i), 1'b1);
    @(posedge clk); #1 ready_i = '0;
    chk("ch0_empty", 64'(valid_o), 64'h0);

    // Broadcast blocked by a full channel, then released.
    offer(3, 1'b0, 8'h33, 1'b1);
    offer(0, 1'b1, 8'h77, 1'b1);
    ready_i = 4'b1000;
    offer(0, 1'b1, 8'h77, 1'b1);
    chk("bcast_1111", 64'(valid_o), 64'hF);
    chk("bcast_res", 64'(result_o), 64'h77777777);
    ready_i = 4'b1111;
    @(posedge clk); #1 ready_i = '0;

    // Random traffic against the scoreboard.
    for (int i = 0; i < 80; i++) begin
      ready_i = 4'($urandom);
      offer(int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
            8'($urandom), 1'($urandom_range(0, 1)));
    end
    ready_i = 4'b1111;
    @(posedge clk); #1 ready_i = '0;

    // Fill A channels 1,2; B channels 1,2 plus five discards; then reset pulse.
    offer(1, 1'b0, 8'hC1, 1'b1);
    offer(2, 1'b0, 8'hC2, 1'b1);
    b_offer(2'd1, 8'h11, 1'b1);
    b_offer(2'd2, 8'h22, 1'b1);
    for (int i = 0; i < 5; i++) b_offer(2'd3, 8'(i), 1'b1);
    chk("b_valid_110", 64'(b_valid_o), 64'h6);
    chk("b_result", 64'(b_result), 64'h221100);
    chk("b_drop5", 64'(b_drop), 64'h5);
    b_offer(2'd1, 8'hEE, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_a_valid", 64'(valid_o), 64'h0);
    chk("pulse_a_result", 64'(result_o), 64'h0);
    chk("pulse_b_valid", 64'(b_valid_o), 64'h0);
    chk("pulse_b_result", 64'(b_result), 64'h0);
    chk("pulse_b_drop", 64'(b_drop), 64'h0);
    for (int k = 0; k < 4; k++) q[k].delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    b_offer(2'd1, 8'h44, 1'b1);
    chk("b_post_valid", 64'(b_valid_o), 64'h2);
    chk("b_post_res", 64'(b_result), 64'h004400);
    offer(1, 1'b0, 8'h45, 1'b1);

    // Out-of-range select saturates the discard counter, channels untouched.
    for (int i = 0; i < 300; i++) begin
      b_offer(2'd3, 8'(i), 1'b1);
      chk("b_hold_valid", 64'(b_valid_o), 64'h2);
      if (i == 253) chk("b_drop254", 64'(b_drop), 64'd254);
    end
    chk("b_drop_sat", 64'(b_drop), 64'd255);
    chk("b_hold_res", 64'(b_result), 64'h004400);

    ready_i = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
